// File: rtl/random_pkg.sv
`default_nettype none
// ============================================================================
// Module      : random_pkg
// Description : Shared constants, rewind FSM states and xorshift32 helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package random_pkg;

   localparam int c_WIDTH   = 32;
   localparam int c_SHIFT_A = 13;
   localparam int c_SHIFT_B = 17;
   localparam int c_SHIFT_C = 5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_UNDO_C = 3'd1,
      ST_UNDO_B = 3'd2,
      ST_UNDO_A = 3'd3,
      ST_FINISH = 3'd4
   } rewind_state_t;

   // Iterations needed to undo x ^= x shifted by k: ceil(WIDTH/k) - 1.
   function automatic int ceil_iters(input int k);
      return (c_WIDTH + k - 1) / k - 1;
   endfunction

   function automatic logic [c_WIDTH-1:0] xorshift32_step(input logic [c_WIDTH-1:0] x);
      logic [c_WIDTH-1:0] t;
      t = x ^ (x << c_SHIFT_A);
      t = t ^ (t >> c_SHIFT_B);
      t = t ^ (t << c_SHIFT_C);
      return t;
   endfunction

endpackage
`default_nettype wire

// File: rtl/xorshift_unshift_iter.sv
`default_nettype none
// ============================================================================
// Module      : xorshift_unshift_iter
// Description : One fixed-point iteration of undoing y = x ^ (x shift k).
// Revision    : 1.0 - initial release
// ============================================================================
module xorshift_unshift_iter
   import random_pkg::*;
(
   input  logic [c_WIDTH-1:0] i_Y,
   input  logic [c_WIDTH-1:0] i_X,
   input  logic               i_Right,
   input  logic [4:0]         i_Shift,
   output logic [c_WIDTH-1:0] o_X
);

   assign o_X = i_Right ? (i_Y ^ (i_X >> i_Shift)) : (i_Y ^ (i_X << i_Shift));

endmodule
`default_nettype wire

// File: rtl/xorshift32_rewind.sv
`default_nettype none
// ============================================================================
// Module      : xorshift32_rewind
// Description : Iterative inverse of xorshift32; returns the state i_Steps draws back.
// Revision    : 1.0 - initial release
// ============================================================================
module xorshift32_rewind
   import random_pkg::*;
#(
   parameter int SHIFT_A = c_SHIFT_A,
   parameter int SHIFT_B = c_SHIFT_B,
   parameter int SHIFT_C = c_SHIFT_C,
   parameter int STEP_W  = 8
)(
   input  logic               i_Clk,
   input  logic               i_Reset,
   input  logic               i_Start,
   input  logic [c_WIDTH-1:0] i_State,
   input  logic [STEP_W-1:0]  i_Steps,
   output logic               o_Busy,
   output logic               o_Done,
   output logic [c_WIDTH-1:0] o_State
);

   localparam int c_N_A = ceil_iters(SHIFT_A);
   localparam int c_N_B = ceil_iters(SHIFT_B);
   localparam int c_N_C = ceil_iters(SHIFT_C);

   rewind_state_t       r_state;
   logic [c_WIDTH-1:0]  r_y;
   logic [c_WIDTH-1:0]  r_x;
   logic [4:0]          r_iter;
   logic [STEP_W-1:0]   r_steps;
   logic                r_busy;
   logic                r_done;
   logic [c_WIDTH-1:0]  r_out;

   logic [4:0]          w_shift;
   logic                w_right;
   logic                w_last;
   logic [c_WIDTH-1:0]  w_x_next;

   always_comb begin
      w_shift = 5'(SHIFT_C);
      w_right = 1'b0;
      w_last  = 1'b0;
      case (r_state)
         ST_UNDO_C: w_last = (r_iter == 5'(c_N_C - 1));
         ST_UNDO_B: begin
            w_shift = 5'(SHIFT_B);
            w_right = 1'b1;
            w_last  = (r_iter == 5'(c_N_B - 1));
         end
         ST_UNDO_A: begin
            w_shift = 5'(SHIFT_A);
            w_last  = (r_iter == 5'(c_N_A - 1));
         end
         default: ;
      endcase
   end

   xorshift_unshift_iter u_iter (
      .i_Y     (r_y),
      .i_X     (r_x),
      .i_Right (w_right),
      .i_Shift (w_shift),
      .o_X     (w_x_next)
   );

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_state <= ST_IDLE;
         r_y     <= '0;
         r_x     <= '0;
         r_iter  <= '0;
         r_steps <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_out   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: if (i_Start) begin
               r_y     <= i_State;
               r_x     <= i_State;
               r_steps <= i_Steps;
               r_iter  <= '0;
               if (i_Steps == '0) begin
                  r_state <= ST_FINISH;
                  r_done  <= 1'b1;
                  r_out   <= i_State;
               end else begin
                  r_state <= ST_UNDO_C;
                  r_busy  <= 1'b1;
               end
            end
            ST_UNDO_C, ST_UNDO_B, ST_UNDO_A: begin
               r_x <= w_x_next;
               if (w_last) begin
                  // The finished term becomes the y of the next undo stage.
                  r_iter <= '0;
                  r_y    <= w_x_next;
                  if (r_state == ST_UNDO_C) begin
                     r_state <= ST_UNDO_B;
                  end else if (r_state == ST_UNDO_B) begin
                     r_state <= ST_UNDO_A;
                  end else begin
                     r_steps <= r_steps - 1'b1;
                     if (r_steps != STEP_W'(1)) begin
                        r_state <= ST_UNDO_C;
                     end else begin
                        r_state <= ST_FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_out   <= w_x_next;
                     end
                  end
               end else begin
                  r_iter <= r_iter + 1'b1;
               end
            end
            ST_FINISH: r_state <= ST_IDLE;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_Busy  = r_busy;
   assign o_Done  = r_done;
   assign o_State = r_out;

endmodule
`default_nettype wire

// File: tb/tb_xorshift32_rewind.sv
`default_nettype none
// ============================================================================
// Module      : tb_xorshift32_rewind
// Description : Self-checking bench for xorshift32_rewind against a forward model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xorshift32_rewind;

   localparam int STEP_W = 8;

   logic              i_Clk = 1'b0;
   logic              i_Reset = 1'b0;
   logic              i_Start = 1'b0;
   logic [31:0]       i_State = '0;
   logic [STEP_W-1:0] i_Steps = '0;
   logic              o_Busy;
   logic              o_Done;
   logic [31:0]       o_State;

   int errors = 0;
   int checks = 0;

   xorshift32_rewind #(.SHIFT_A(13), .SHIFT_B(17), .SHIFT_C(5), .STEP_W(STEP_W)) dut (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Start (i_Start),
      .i_State (i_State),
      .i_Steps (i_Steps),
      .o_Busy  (o_Busy),
      .o_Done  (o_Done),
      .o_State (o_State)
   );

   always #5 i_Clk = ~i_Clk;

   // Reference: the forward generator applied n times.
   function automatic logic [31:0] fwd_n(input logic [31:0] x, input int n);
      logic [31:0] v;
      v = x;
      for (int i = 0; i < n; i++) begin
         v = v ^ (v << 13);
         v = v ^ (v >> 17);
         v = v ^ (v << 5);
      end
      return v;
   endfunction

   // Launches one run and observes it; start pulses are injected at cycles poke_a/poke_b.
   task automatic do_run(input logic [31:0] st, input int s, input int poke_a, input int poke_b,
                         output logic [31:0] res, output int done_k, output int n_done,
                         output int busy_bad);
      int lim;
      lim = 9 * s + 3;
      @(negedge i_Clk);
      i_Start = 1'b1;
      i_State = st;
      i_Steps = STEP_W'(s);
      @(posedge i_Clk);
      #1;
      i_Start = 1'b0;
      i_State = $urandom;
      i_Steps = STEP_W'($urandom);
      done_k = -1; n_done = 0; busy_bad = 0; res = '0;
      for (int k = 1; k <= lim; k++) begin
         @(negedge i_Clk);
         if (o_Busy !== (k <= 9 * s)) busy_bad++;
         if (o_Done === 1'b1) begin
            n_done++;
            if (done_k < 0) begin
               done_k = k;
               res    = o_State;
            end
         end
         i_Start = (k == poke_a) || (k == poke_b);
      end
      i_Start = 1'b0;
   endtask

   task automatic test_reset;
      i_Reset = 1'b1;
      repeat (3) @(posedge i_Clk);
      #1 i_Reset = 1'b0;
      @(negedge i_Clk);
      checks++;
      if ({o_Busy, o_Done, o_State} !== 34'd0) begin
         errors++;
         $display("FAIL reset: busy=%b done=%b state=%h expected 0 0 00000000", o_Busy, o_Done, o_State);
      end
   endtask

   task automatic test_directed(input string name, input logic [31:0] st, input int s,
                                input logic [31:0] exp);
      logic [31:0] res; int dk, nd, bb;
      do_run(st, s, -1, -1, res, dk, nd, bb);
      checks++;
      if (res !== exp) begin
         errors++;
         $display("FAIL %s value: got %h expected %h", name, res, exp);
      end
      checks++;
      if (dk !== 9 * s + 1 || nd !== 1) begin
         errors++;
         $display("FAIL %s done: at T+%0d count %0d expected T+%0d count 1", name, dk, nd, 9 * s + 1);
      end
      checks++;
      if (bb !== 0) begin
         errors++;
         $display("FAIL %s busy: %0d bad cycles expected 0", name, bb);
      end
   endtask

   task automatic test_ignored_start;
      logic [31:0] res; int dk, nd, bb;
      do_run(32'h1234_5678, 2, 3, 19, res, dk, nd, bb);
      checks++;
      if (fwd_n(res, 2) !== 32'h1234_5678 || dk !== 19 || nd !== 1 || bb !== 0) begin
         errors++;
         $display("FAIL ignored_start: res=%h done_at=%0d count=%0d busy_bad=%0d expected fwd2=12345678 19 1 0",
                  res, dk, nd, bb);
      end
      repeat (3) @(negedge i_Clk);
      checks++;
      if (o_State !== res || o_Busy !== 1'b0) begin
         errors++;
         $display("FAIL ignored_hold: state=%h busy=%b expected %h 0", o_State, o_Busy, res);
      end
   endtask

   task automatic test_mid_reset;
      int nd;
      logic [31:0] res; int dk, nd2, bb;
      @(negedge i_Clk);
      i_Start = 1'b1; i_State = 32'hCAFE_F00D; i_Steps = STEP_W'(3);
      @(posedge i_Clk);
      #1 i_Start = 1'b0;
      repeat (3) @(negedge i_Clk);
      @(negedge i_Clk);
      i_Reset = 1'b1;
      @(posedge i_Clk);
      #1 i_Reset = 1'b0;
      @(negedge i_Clk);
      checks++;
      if ({o_Busy, o_Done, o_State} !== 34'd0) begin
         errors++;
         $display("FAIL mid_reset: busy=%b done=%b state=%h expected 0 0 00000000", o_Busy, o_Done, o_State);
      end
      nd = 0;
      repeat (30) begin
         @(negedge i_Clk);
         if (o_Done === 1'b1 || o_Busy === 1'b1) nd++;
      end
      checks++;
      if (nd !== 0) begin
         errors++;
         $display("FAIL mid_reset_quiet: %0d active cycles expected 0", nd);
      end
      do_run(32'hCAFE_F00D, 3, -1, -1, res, dk, nd2, bb);
      checks++;
      if (fwd_n(res, 3) !== 32'hCAFE_F00D || dk !== 28 || nd2 !== 1 || bb !== 0) begin
         errors++;
         $display("FAIL mid_reset_rerun: res=%h done_at=%0d count=%0d busy_bad=%0d expected fwd3=cafef00d 28 1 0",
                  res, dk, nd2, bb);
      end
   endtask

   task automatic test_max_steps;
      logic [31:0] st, res; int dk, nd, bb;
      st = $urandom;
      do_run(st, 255, -1, -1, res, dk, nd, bb);
      checks++;
      if (fwd_n(res, 255) !== st || dk !== 9 * 255 + 1 || nd !== 1 || bb !== 0) begin
         errors++;
         $display("FAIL max_steps: res=%h done_at=%0d count=%0d busy_bad=%0d expected fwd255=%h %0d 1 0",
                  res, dk, nd, bb, st, 9 * 255 + 1);
      end
   endtask

   task automatic test_random;
      logic [31:0] st, res; int s, dk, nd, bb;
      for (int n = 0; n < 1000; n++) begin
         st = $urandom;
         s  = $urandom_range(0, 4);
         do_run(st, s, -1, -1, res, dk, nd, bb);
         checks++;
         if (fwd_n(res, s) !== st) begin
            errors++;
            $display("FAIL random_value: in=%h S=%0d got %h fwd=%h expected fwd=%h", st, s, res, fwd_n(res, s), st);
         end
         checks++;
         if (dk !== 9 * s + 1 || nd !== 1 || bb !== 0) begin
            errors++;
            $display("FAIL random_timing: S=%0d done_at=%0d count=%0d busy_bad=%0d expected %0d 1 0",
                     s, dk, nd, bb, 9 * s + 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed("low_bit", 32'h0004_2021, 1, 32'h0000_0001);
      test_directed("high_bit", 32'h8008_4000, 1, 32'h8000_0000);
      test_directed("five_steps", fwd_n(32'h4242_4242, 5), 5, 32'h4242_4242);
      test_directed("zero_steps", 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
      test_directed("fixed_point", 32'h0000_0000, 2, 32'h0000_0000);
      test_ignored_start();
      test_mid_reset();
      test_max_steps();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
